store_queue: RTL and testbench
==============================

# store_queue

In-order store buffer sitting beside the ROB between dispatch and data memory. Allocates one entry per dispatched store and captures address/data from the execute stage. Marks the oldest store committed when the ROB head is that store, then drains it to memory through a req/grant handshake. Squash discards every uncommitted entry; committed stores always reach memory.

## Interface
- SQ_LEN, 8, entries (power of two, ≥2)
- XLEN, 32, address/data width
- ROB_IDX_W, 5, ROB tag width
- clock  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high
- squash  in  1  ROB squash (mispredict at head)
- disp_valid  in  1  dispatch a store this cycle
- disp_rob_idx  in  ROB_IDX_W  ROB entry of dispatched store
- disp_sq_idx  out  log2(SQ_LEN)  tail index (entry a dispatch would get)
- sq_full  out  1  count == SQ_LEN
- ex_valid  in  1  execute delivers address/data
- ex_sq_idx  in  log2(SQ_LEN)  target entry
- ex_addr / ex_data  in  XLEN  store address / data
- ex_size  in  2  0=byte,1=half,2=word
- rob_store_start  in  1  ROB head is a store
- rob_head_idx  in  ROB_IDX_W  current ROB head index
- mem_req  out  1  write request
- mem_addr / mem_data  out  XLEN  request payload
- mem_size  out  2  request size
- mem_grant  in  1  memory accepted request
- store_done  out  1  one-cycle pulse: head store written
- store_done_rob_idx  out  ROB_IDX_W  ROB tag of written store

## Operation
- Entry fields: valid, ready (addr/data captured), committed, rob_idx, addr, data, size. head, tail, count registers; indices wrap modulo SQ_LEN.
- Dispatch: disp_valid && !sq_full && !squash writes entry[tail] (valid=1, ready=0, committed=0, rob_idx), tail+1, count+1. Dispatch while full or during squash is dropped.
- Execute: ex_valid writes addr/data/size to entry[ex_sq_idx], ready=1. Write to an invalid entry ignored.
- Commit: entry[head] valid && ready && !committed && rob_store_start && entry[head].rob_idx == rob_head_idx sets committed=1. At most one commit per cycle; rob_idx match prevents double-commit while rob_store_start stays high.
- Drain FSM: IDLE -> REQ when entry[head].committed. REQ: mem_req=1, payload from entry[head], held stable until mem_grant. Grant: clear entry[head], head+1, count−1, pulse store_done with rob_idx, return IDLE.
- Squash: all entries with committed=0 cleared; tail = head + number of committed entries (0 or 1); count matches. FSM state and in-flight request unaffected. Execute writes in the squash cycle dropped.
- Simultaneous dispatch and grant: both apply; count unchanged. Full is computed from current count: dispatch rejected when full even if grant frees an entry that cycle.
- count arithmetic uses log2(SQ_LEN)+1 bits; full vs empty distinguished by count, not head==tail.

## Timing
- Reset: all entries invalid, head=tail=count=0, FSM IDLE; outputs 0 (sq_full=0, disp_sq_idx=0, mem_req=0, mem_addr/data/size=0, store_done=0, store_done_rob_idx=0). Reset mid-request drops mem_req the cycle after the reset edge; no store_done.
- disp_sq_idx/sq_full combinational from registers; allocation visible next cycle.
- Commit registered; mem_req rises the cycle after commit edge (earliest 1 cycle after rob_store_start matches).
- Same-cycle grant: store_done pulses the cycle after grant edge; FSM returns to IDLE and next committed head requests one cycle later (one idle bubble between stores).
- mem_req/payload must not change while mem_req=1 and mem_grant=0.

## Test plan
- Reset, dispatch rob 3 at sq 0, ex addr 0x100 data 0xDEADBEEF size 2, rob_store_start with head 3 -> mem_req next cycle with 0x100/0xDEADBEEF; grant -> store_done with rob_idx 3, count 0.
- Dispatch 8 stores -> sq_full=1, 9th dispatch ignored, disp_sq_idx wraps to 0; drain one -> sq_full=0, next dispatch lands at index 0.
- Hold mem_grant low 5 cycles -> mem_req and payload stable all 5; rob_store_start held high with same rob_head_idx -> exactly one store_done.
- Three stores, head committed and in REQ, squash -> entries 1-2 cleared, tail=head+1, committed store still granted and store_done pulses.
- Dispatch and grant in same cycle at count 4 -> count stays 4, tail and head both advance.
- Assert reset during REQ -> mem_req=0 next cycle, no store_done, sq_full=0, count 0.

Source files
------------

// File: rtl/store_queue.sv
// In-order store buffer: allocates at dispatch, captures address/data at execute,
// commits the oldest store when the ROB head reaches it, and drains it over req/grant.
module store_queue #(
  parameter int SQ_LEN    = 8,
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic                       disp_valid,
  input  logic [ROB_IDX_W-1:0]       disp_rob_idx,
  output logic [$clog2(SQ_LEN)-1:0]  disp_sq_idx,
  output logic                       sq_full,
  input  logic                       ex_valid,
  input  logic [$clog2(SQ_LEN)-1:0]  ex_sq_idx,
  input  logic [XLEN-1:0]            ex_addr,
  input  logic [XLEN-1:0]            ex_data,
  input  logic [1:0]                 ex_size,
  input  logic                       rob_store_start,
  input  logic [ROB_IDX_W-1:0]       rob_head_idx,
  output logic                       mem_req,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_data,
  output logic [1:0]                 mem_size,
  input  logic                       mem_grant,
  output logic                       store_done,
  output logic [ROB_IDX_W-1:0]       store_done_rob_idx
);

  localparam int IDX_W = $clog2(SQ_LEN);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [SQ_LEN-1:0]    ent_valid;
  logic [SQ_LEN-1:0]    ent_ready;
  logic [SQ_LEN-1:0]    ent_committed;
  logic [ROB_IDX_W-1:0] ent_rob  [SQ_LEN];
  logic [XLEN-1:0]      ent_addr [SQ_LEN];
  logic [XLEN-1:0]      ent_data [SQ_LEN];
  logic [1:0]           ent_size [SQ_LEN];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head_next;

  logic full;
  logic disp_fire;
  logic ex_fire;
  logic commit_fire;
  logic grant_fire;
  logic keep_head;

  assign full        = (count == CNT_W'(SQ_LEN));
  assign sq_full     = full;
  assign disp_sq_idx = tail;

  assign disp_fire   = disp_valid && !full && !squash;
  assign ex_fire     = ex_valid && !squash && ent_valid[ex_sq_idx];
  assign grant_fire  = (state == REQ) && mem_grant;
  assign commit_fire = !squash && rob_store_start && ent_valid[head] && ent_ready[head] &&
                       !ent_committed[head] && (ent_rob[head] == rob_head_idx);
  assign head_next   = grant_fire ? head + IDX_W'(1) : head;
  // Only the head can be committed, so at most one entry survives a squash.
  assign keep_head   = ent_valid[head] && ent_committed[head] && !grant_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid     <= '0;
      ent_ready     <= '0;
      ent_committed <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
    end else begin
      if (ex_fire) begin
        ent_addr[ex_sq_idx]  <= ex_addr;
        ent_data[ex_sq_idx]  <= ex_data;
        ent_size[ex_sq_idx]  <= ex_size;
        ent_ready[ex_sq_idx] <= 1'b1;
      end
      if (commit_fire) begin
        ent_committed[head] <= 1'b1;
      end
      if (disp_fire) begin
        ent_valid[tail]     <= 1'b1;
        ent_ready[tail]     <= 1'b0;
        ent_committed[tail] <= 1'b0;
        ent_rob[tail]       <= disp_rob_idx;
        tail                <= tail + IDX_W'(1);
      end
      if (grant_fire) begin
        ent_valid[head]     <= 1'b0;
        ent_ready[head]     <= 1'b0;
        ent_committed[head] <= 1'b0;
      end
      head <= head_next;
      if (squash) begin
        for (int i = 0; i < SQ_LEN; i++) begin
          if (!ent_committed[i]) begin
            ent_valid[i] <= 1'b0;
            ent_ready[i] <= 1'b0;
          end
        end
        tail  <= head_next + IDX_W'(keep_head);
        count <= CNT_W'(keep_head);
      end else begin
        count <= count + CNT_W'(disp_fire) - CNT_W'(grant_fire);
      end
    end
  end

  // A commit this cycle launches the request directly, so mem_req follows the commit edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      mem_req            <= 1'b0;
      mem_addr           <= '0;
      mem_data           <= '0;
      mem_size           <= '0;
      store_done         <= 1'b0;
      store_done_rob_idx <= '0;
    end else begin
      store_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ent_valid[head] && (ent_committed[head] || commit_fire)) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= ent_addr[head];
            mem_data <= ent_data[head];
            mem_size <= ent_size[head];
          end
        end
        REQ: begin
          if (mem_grant) begin
            state              <= IDLE;
            mem_req            <= 1'b0;
            store_done         <= 1'b1;
            store_done_rob_idx <= ent_rob[head];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_store_queue;

  localparam int SQ_LEN    = 8;
  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 squash;
  logic                 disp_valid;
  logic [ROB_IDX_W-1:0] disp_rob_idx;
  logic [2:0]           disp_sq_idx;
  logic                 sq_full;
  logic                 ex_valid;
  logic [2:0]           ex_sq_idx;
  logic [XLEN-1:0]      ex_addr;
  logic [XLEN-1:0]      ex_data;
  logic [1:0]           ex_size;
  logic                 rob_store_start;
  logic [ROB_IDX_W-1:0] rob_head_idx;
  logic                 mem_req;
  logic [XLEN-1:0]      mem_addr;
  logic [XLEN-1:0]      mem_data;
  logic [1:0]           mem_size;
  logic                 mem_grant;
  logic                 store_done;
  logic [ROB_IDX_W-1:0] store_done_rob_idx;

  store_queue #(.SQ_LEN(SQ_LEN), .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_rob_idx(disp_rob_idx),
    .disp_sq_idx(disp_sq_idx), .sq_full(sq_full),
    .ex_valid(ex_valid), .ex_sq_idx(ex_sq_idx), .ex_addr(ex_addr),
    .ex_data(ex_data), .ex_size(ex_size),
    .rob_store_start(rob_store_start), .rob_head_idx(rob_head_idx),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_size(mem_size), .mem_grant(mem_grant),
    .store_done(store_done), .store_done_rob_idx(store_done_rob_idx)
  );

  always #5 clock = ~clock;

  int npass  = 0;
  int ntotal = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [ROB_IDX_W-1:0] rob;
    bit                   ready;
    bit                   committed;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      data;
    logic [1:0]           size;
  } ent_t;

  // Reference model: oldest store at q[0]; mhead is the buffer slot of q[0].
  ent_t                 q[$];
  ent_t                 kept[$];
  ent_t                 e;
  int                   mhead;
  int                   pos;
  bit                   mreq;
  bit                   mdone;
  bit                   grant_now;
  bit                   disp_ok;
  bit                   commit_now;
  logic [XLEN-1:0]      maddr;
  logic [XLEN-1:0]      mdata;
  logic [1:0]           msize;
  logic [ROB_IDX_W-1:0] mdone_rob;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      mhead = 0; mreq = 0; mdone = 0;
      maddr = '0; mdata = '0; msize = '0; mdone_rob = '0;
    end else begin
      grant_now  = mreq && (mem_grant === 1'b1);
      disp_ok    = disp_valid && !squash && (q.size() < SQ_LEN);
      commit_now = !squash && rob_store_start && (q.size() > 0) && q[0].ready &&
                   !q[0].committed && (q[0].rob == rob_head_idx);
      mdone = 1'b0;
      if (!mreq && q.size() > 0 && (q[0].committed || commit_now)) begin
        mreq = 1'b1; maddr = q[0].addr; mdata = q[0].data; msize = q[0].size;
      end
      if (ex_valid && !squash) begin
        pos = (int'(ex_sq_idx) - mhead + SQ_LEN) % SQ_LEN;
        if (pos < q.size()) begin
          e = q[pos];
          e.ready = 1'b1; e.addr = ex_addr; e.data = ex_data; e.size = ex_size;
          q[pos] = e;
        end
      end
      if (commit_now) begin
        e = q[0]; e.committed = 1'b1; q[0] = e;
      end
      if (grant_now) begin
        mdone = 1'b1; mdone_rob = q[0].rob;
        void'(q.pop_front());
        mhead = (mhead + 1) % SQ_LEN;
        mreq = 1'b0;
      end
      if (disp_ok) begin
        e.rob = disp_rob_idx; e.ready = 0; e.committed = 0;
        e.addr = '0; e.data = '0; e.size = '0;
        q.push_back(e);
      end
      if (squash) begin
        kept.delete();
        foreach (q[i]) if (q[i].committed) kept.push_back(q[i]);
        q = kept;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      checkOutput("sq_full", 64'(sq_full), 64'(q.size() == SQ_LEN));
      checkOutput("disp_sq_idx", 64'(disp_sq_idx), 64'((mhead + q.size()) % SQ_LEN));
      checkOutput("mem_req", 64'(mem_req), 64'(mreq));
      if (mreq) begin
        checkOutput("mem_addr", 64'(mem_addr), 64'(maddr));
        checkOutput("mem_data", 64'(mem_data), 64'(mdata));
        checkOutput("mem_size", 64'(mem_size), 64'(msize));
      end
      checkOutput("store_done", 64'(store_done), 64'(mdone));
      if (mdone) checkOutput("store_done_rob_idx", 64'(store_done_rob_idx), 64'(mdone_rob));
    end
  end

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      disp_valid = 1'b0;
      ex_valid   = 1'b0;
      squash     = 1'b0;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
  endtask

  task automatic dispatch(input int rob);
    disp_valid = 1'b1; disp_rob_idx = ROB_IDX_W'(rob);
    applyStimulus(1);
  endtask

  task automatic execute(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ex_valid = 1'b1; ex_sq_idx = 3'(idx); ex_addr = a; ex_data = d; ex_size = s;
    applyStimulus(1);
  endtask

  task automatic commit(input int rob);
    rob_store_start = 1'b1; rob_head_idx = ROB_IDX_W'(rob);
    applyStimulus(1);
    rob_store_start = 1'b0;
  endtask

  task automatic grant();
    mem_grant = 1'b1;
    applyStimulus(1);
    mem_grant = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; squash = 0; disp_valid = 0; disp_rob_idx = 0;
    ex_valid = 0; ex_sq_idx = 0; ex_addr = 0; ex_data = 0; ex_size = 0;
    rob_store_start = 0; rob_head_idx = 0; mem_grant = 0;
    doReset();
    chk_en = 1'b1;
    checkOutput("rst_sq_full", 64'(sq_full), 64'd0);
    checkOutput("rst_disp_idx", 64'(disp_sq_idx), 64'd0);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_done_rob", 64'(store_done_rob_idx), 64'd0);

    // Single store end to end.
    dispatch(3);
    checkOutput("s1_disp_idx", 64'(disp_sq_idx), 64'd1);
    execute(0, 32'h100, 32'hDEADBEEF, 2'd2);
    commit(3);
    checkOutput("s1_mem_req", 64'(mem_req), 64'd1);
    checkOutput("s1_mem_addr", 64'(mem_addr), 64'h100);
    checkOutput("s1_mem_data", 64'(mem_data), 64'hDEADBEEF);
    grant();
    checkOutput("s1_done", 64'(store_done), 64'd1);
    checkOutput("s1_done_rob", 64'(store_done_rob_idx), 64'd3);
    applyStimulus(1);
    checkOutput("s1_done_clear", 64'(store_done), 64'd0);

    // Fill, overflow, drain one, refill at slot 0; then hold grant low.
    doReset();
    for (int i = 0; i < 8; i++) dispatch(10 + i);
    checkOutput("full_set", 64'(sq_full), 64'd1);
    checkOutput("full_wrap_idx", 64'(disp_sq_idx), 64'd0);
    dispatch(20);
    checkOutput("full_drop", 64'(sq_full), 64'd1);
    execute(0, 32'h200, 32'h0000AAAA, 2'd2);
    commit(10);
    grant();
    checkOutput("drain_not_full", 64'(sq_full), 64'd0);
    checkOutput("drain_idx", 64'(disp_sq_idx), 64'd0);
    dispatch(21);
    checkOutput("refill_idx", 64'(disp_sq_idx), 64'd1);
    checkOutput("refill_full", 64'(sq_full), 64'd1);
    execute(1, 32'h204, 32'h12345678, 2'd1);
    rob_store_start = 1'b1; rob_head_idx = 5'd11;
    applyStimulus(1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_req", 64'(mem_req), 64'd1);
      checkOutput("hold_addr", 64'(mem_addr), 64'h204);
      checkOutput("hold_data", 64'(mem_data), 64'h12345678);
      checkOutput("hold_size", 64'(mem_size), 64'd1);
      applyStimulus(1);
    end
    grant();
    checkOutput("hold_done", 64'(store_done), 64'd1);
    checkOutput("hold_done_rob", 64'(store_done_rob_idx), 64'd11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("no_double_done", 64'(store_done), 64'd0);
      checkOutput("no_double_req", 64'(mem_req), 64'd0);
    end
    rob_store_start = 1'b0;

    // Dispatch and grant in the same cycle at count 4.
    doReset();
    for (int i = 1; i <= 4; i++) dispatch(i);
    execute(0, 32'h300, 32'h11112222, 2'd2);
    commit(1);
    disp_valid = 1'b1; disp_rob_idx = 5'd5; mem_grant = 1'b1;
    applyStimulus(1);
    mem_grant = 1'b0;
    checkOutput("dg_idx", 64'(disp_sq_idx), 64'd5);
    checkOutput("dg_done_rob", 64'(store_done_rob_idx), 64'd1);
    execute(1, 32'h304, 32'hCAFEF00D, 2'd0);
    commit(2);
    checkOutput("dg_next_addr", 64'(mem_addr), 64'h304);
    for (int i = 6; i <= 8; i++) dispatch(i);
    checkOutput("dg_count7", 64'(sq_full), 64'd0);
    dispatch(9);
    checkOutput("dg_count8", 64'(sq_full), 64'd1);

    // Squash with the committed head in flight.
    doReset();
    dispatch(7); dispatch(8); dispatch(9);
    execute(0, 32'h400, 32'h44444444, 2'd2);
    execute(1, 32'h404, 32'h55555555, 2'd2);
    execute(2, 32'h408, 32'h66666666, 2'd2);
    commit(7);
    squash = 1'b1;
    ex_valid = 1'b1; ex_sq_idx = 3'd1; ex_addr = 32'hBAD; ex_data = 32'hBAD; ex_size = 2'd0;
    applyStimulus(1);
    checkOutput("sq_tail", 64'(disp_sq_idx), 64'd1);
    checkOutput("sq_req_kept", 64'(mem_req), 64'd1);
    checkOutput("sq_addr_kept", 64'(mem_addr), 64'h400);
    grant();
    checkOutput("sq_done_rob", 64'(store_done_rob_idx), 64'd7);
    dispatch(10);
    checkOutput("sq_realloc_idx", 64'(disp_sq_idx), 64'd2);
    execute(1, 32'h500, 32'h77777777, 2'd1);
    commit(10);
    checkOutput("sq_realloc_addr", 64'(mem_addr), 64'h500);

    // Reset while a request is outstanding.
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("rr_req", 64'(mem_req), 64'd0);
    checkOutput("rr_done", 64'(store_done), 64'd0);
    checkOutput("rr_full", 64'(sq_full), 64'd0);
    checkOutput("rr_idx", 64'(disp_sq_idx), 64'd0);
    applyStimulus(2);
    checkOutput("rr_no_done", 64'(store_done), 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
